// File: rtl/output_fifo_stage.sv
// output_fifo_stage: tagged FWFT output buffer with valid/ready drain and accumulator narrowing.
// Define OUTPUT_FIFO_SAT_EN for signed saturation on narrowing; otherwise the data is truncated.
module output_fifo_stage #(
    parameter int ACC_WIDTH   = 32,
    parameter int OUT_WIDTH   = 16,
    parameter int COORD_WIDTH = 32,
    parameter int DEPTH       = 8
) (
    input  logic                         clk,
    input  logic                         arst_n_in,
    input  logic                         clear,
    input  logic                         in_valid,
    input  logic [ACC_WIDTH-1:0]         in_data,
    input  logic [COORD_WIDTH-1:0]       in_x,
    input  logic [COORD_WIDTH-1:0]       in_y,
    input  logic [COORD_WIDTH-1:0]       in_ch,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_WIDTH-1:0]         out_data,
    output logic [COORD_WIDTH-1:0]       out_x,
    output logic [COORD_WIDTH-1:0]       out_y,
    output logic [COORD_WIDTH-1:0]       out_ch,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [OUT_WIDTH-1:0]   mem_d  [DEPTH];
    logic [COORD_WIDTH-1:0] mem_x  [DEPTH];
    logic [COORD_WIDTH-1:0] mem_y  [DEPTH];
    logic [COORD_WIDTH-1:0] mem_ch [DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [OUT_WIDTH-1:0]   narrow;
    logic                   push, pop;

`ifdef OUTPUT_FIFO_SAT_EN
    logic [ACC_WIDTH-OUT_WIDTH:0] upper;
    logic                         clip;
    assign upper = in_data[ACC_WIDTH-1:OUT_WIDTH-1];
    assign clip  = !(&upper || ~|upper);
    assign narrow = !clip ? in_data[OUT_WIDTH-1:0] :
                    in_data[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} :
                    {1'b0, {(OUT_WIDTH-1){1'b1}}};
`else
    logic unused_hi;
    assign unused_hi = ^in_data;
    assign narrow    = in_data[OUT_WIDTH-1:0];
`endif

    assign full      = count == CW'(DEPTH);
    assign out_valid = count != '0;
    assign pop       = out_valid && out_ready;
    assign push      = in_valid && (!full || pop);
    assign out_data  = mem_d[rd_ptr];
    assign out_x     = mem_x[rd_ptr];
    assign out_y     = mem_y[rd_ptr];
    assign out_ch    = mem_ch[rd_ptr];

    // Entry storage: zeroed by reset, written on accepted push; clear leaves contents alone.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i]  <= '0;
                mem_x[i]  <= '0;
                mem_y[i]  <= '0;
                mem_ch[i] <= '0;
            end
        end else if (!clear && push) begin
            mem_d[wr_ptr]  <= narrow;
            mem_x[wr_ptr]  <= in_x;
            mem_y[wr_ptr]  <= in_y;
            mem_ch[wr_ptr] <= in_ch;
        end
    end

    // Pointers, occupancy and sticky overflow; clear outranks any push or pop.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop) count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
            if (in_valid && !push) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_output_fifo_stage.sv
// tb_output_fifo_stage: directed scoreboard bench for output_fifo_stage (honours OUTPUT_FIFO_SAT_EN).
module tb_output_fifo_stage;
    typedef struct packed {
        logic [15:0] d;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] ch;
    } ent_t;

    logic        clk = 1'b0;
    logic        arst_n_in, clear, in_valid, out_ready;
    logic [31:0] in_data, in_x, in_y, in_ch;
    logic        out_valid, full, overflow;
    logic [15:0] out_data;
    logic [31:0] out_x, out_y, out_ch;
    logic [3:0]  count;

    ent_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    output_fifo_stage dut (
        .clk(clk), .arst_n_in(arst_n_in), .clear(clear),
        .in_valid(in_valid), .in_data(in_data), .in_x(in_x), .in_y(in_y), .in_ch(in_ch),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_x(out_x), .out_y(out_y), .out_ch(out_ch),
        .count(count), .full(full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic [15:0] e,
                        input logic [31:0] x, input logic [31:0] y, input logic [31:0] ch,
                        input bit accepted);
        in_valid = 1'b1;
        in_data  = d;
        in_x     = x;
        in_y     = y;
        in_ch    = ch;
        if (accepted) q.push_back('{d: e, x: x, y: y, ch: ch});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        out_ready = 1'b1;
        repeat (n) tick();
        out_ready = 1'b0;
    endtask

    // Monitor: every handshake seen mid-cycle must match the scoreboard head.
    always @(negedge clk) begin
        if (arst_n_in && !clear && out_valid && out_ready) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL pop_unexpected: got d=%0h x=%0h with empty scoreboard", out_data, out_x);
            end else begin
                ent_t e;
                e = q.pop_front();
                if ({out_data, out_x, out_y, out_ch} !== e) begin
                    miscompares++;
                    $display("FAIL pop_data: got d=%0h x=%0h y=%0h ch=%0h expected d=%0h x=%0h y=%0h ch=%0h",
                             out_data, out_x, out_y, out_ch, e.d, e.x, e.y, e.ch);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        arst_n_in = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        in_x      = '0;
        in_y      = '0;
        in_ch     = '0;
        #8;
        chk("rst_count", 32'(count), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_tags", out_x | out_y | out_ch, 0);
        #4 arst_n_in = 1'b1;
        tick();

        // single push with consumer ready
        out_ready = 1'b1;
        push(32'h0000_0123, 16'h0123, 5, 2, 1, 1'b1);
        chk("single_valid", 32'(out_valid), 1);
        tick();
        out_ready = 1'b0;
        chk("single_count_after", 32'(count), 0);
        chk("single_valid_after", 32'(out_valid), 0);

        // fill under backpressure, then drain in order
        for (int i = 0; i < 8; i++) push(i, 16'(i), i, 0, 0, 1'b1);
        chk("fill_count", 32'(count), 8);
        chk("fill_full", 32'(full), 1);
        chk("fill_overflow", 32'(overflow), 0);
        drain(8);
        chk("drain_count", 32'(count), 0);

        // overflow while full, then clear
        for (int i = 0; i < 8; i++) push(10 + i, 16'(10 + i), i, 1, 0, 1'b1);
        push(99, 16'd99, 9, 9, 9, 1'b0);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_count", 32'(count), 8);
        chk("ovf_head", 32'(out_data), 10);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        q.delete();
        chk("clear_count", 32'(count), 0);
        chk("clear_overflow", 32'(overflow), 0);
        chk("clear_valid", 32'(out_valid), 0);

        // simultaneous push and pop at full
        for (int i = 0; i < 8; i++) push(i, 16'(i), i, 2, 3, 1'b1);
        out_ready = 1'b1;
        push(42, 16'd42, 42, 4, 5, 1'b1);
        out_ready = 1'b0;
        chk("pp_count", 32'(count), 8);
        chk("pp_full", 32'(full), 1);
        chk("pp_overflow", 32'(overflow), 0);
        drain(8);
        chk("pp_drain_count", 32'(count), 0);

        // narrowing
`ifdef OUTPUT_FIFO_SAT_EN
        push(32'h0001_8000, 16'h7FFF, 1, 1, 1, 1'b1);
        push(32'hFFFF_0000, 16'h8000, 2, 2, 2, 1'b1);
`else
        push(32'h0001_8000, 16'h8000, 1, 1, 1, 1'b1);
        push(32'hFFFF_0000, 16'h0000, 2, 2, 2, 1'b1);
`endif
        push(32'hFFFF_FFFE, 16'hFFFE, 3, 3, 3, 1'b1);
        drain(3);

        // asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) push(50 + i, 16'(50 + i), i, 7, 7, 1'b1);
        chk("pre_rst_count", 32'(count), 5);
        #2 arst_n_in = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_count", 32'(count), 0);
        q.delete();
        #1 arst_n_in = 1'b1;
        tick();
        push(77, 16'd77, 8, 6, 4, 1'b1);
        chk("post_rst_count", 32'(count), 1);
        chk("post_rst_head", 32'(out_data), 77);
        drain(1);
        chk("post_rst_empty", 32'(count), 0);
        chk("scoreboard_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
